// File: rtl/complex_alu_seq.sv
// Sequential complex-number ALU. All products go through one shared WxW signed multiplier, with a start/busy/done handshake.
// Build option: define CALU_SAT_EN to clamp out-of-range components instead of wrapping them.
//
// state | meaning
// IDLE  | waiting for start; operands and opcode captured on acceptance
// EXEC  | simple ops write the result; multiply ops clear the accumulators
// MUL   | one product accumulated per cycle
// WB    | scale by FRAC, reduce to W bits, write the result

module complex_alu_seq #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [3:0]     opr,
  input  logic [2*W-1:0] inA,
  input  logic [2*W-1:0] inB,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] outAB,
  output logic           ovf,
  output logic           err
);

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_PASS_B = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_CMUL   = 4'b0100;
  localparam logic [3:0] OP_EMUL   = 4'b0110;
  localparam logic [3:0] OP_EQ     = 4'b1000;
  localparam logic [3:0] OP_CONJ   = 4'b1011;

  localparam logic signed [2*W:0] MAX_V = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MIN_V = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

  state_t              state_q, state_d;
  logic [2*W-1:0]      a_q, a_d, b_q, b_d;
  logic [3:0]          opr_q, opr_d;
  logic [1:0]          step_q, step_d;
  logic signed [2*W:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [2*W-1:0]      out_q, out_d;
  logic                done_q, done_d, ovf_q, ovf_d, err_q, err_d;

  logic [W-1:0] ar, ai, br, bi;
  assign ar = a_q[2*W-1:W];
  assign ai = a_q[W-1:0];
  assign br = b_q[2*W-1:W];
  assign bi = b_q[W-1:0];

  function automatic logic signed [2*W:0] sx(input logic [W-1:0] x);
    return {{(W+1){x[W-1]}}, x};
  endfunction

  // Returns {overflow, W-bit component}.
  function automatic logic [W:0] reduce(input logic signed [2*W:0] v);
    logic         fits;
    logic [W-1:0] r;
    fits = (v <= MAX_V) && (v >= MIN_V);
    if (fits) begin
      r = v[W-1:0];
    end else begin
`ifdef CALU_SAT_EN
      r = v[2*W] ? MIN_V[W-1:0] : MAX_V[W-1:0];
`else
      r = v[W-1:0];
`endif
    end
    return {~fits, r};
  endfunction

  // Operand select for the shared multiplier, indexed by MUL step.
  logic [W-1:0]          mul_a, mul_b;
  logic signed [2*W-1:0] prod;
  logic signed [2*W:0]   prod_x;

  always_comb begin
    mul_a = ar;
    mul_b = br;
    case (step_q)
      2'd1:    begin mul_a = ai; mul_b = bi; end
      2'd2:    begin mul_a = ar; mul_b = bi; end
      2'd3:    begin mul_a = ai; mul_b = br; end
      default: ;
    endcase
  end

  assign prod   = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
  assign prod_x = {prod[2*W-1], prod};

  // Per-component pre-reduction values, shared by EXEC and WB.
  logic signed [2*W:0] re_x, im_x;
  logic [W:0]          red_re, red_im;

  always_comb begin
    re_x = '0;
    im_x = '0;
    if (state_q == S_WB) begin
      re_x = acc_re_q >>> FRAC;
      im_x = acc_im_q >>> FRAC;
    end else begin
      case (opr_q)
        OP_PASS_A: begin re_x = sx(ar);          im_x = sx(ai);          end
        OP_PASS_B: begin re_x = sx(br);          im_x = sx(bi);          end
        OP_ADD:    begin re_x = sx(ar) + sx(br); im_x = sx(ai) + sx(bi); end
        OP_SUB:    begin re_x = sx(ar) - sx(br); im_x = sx(ai) - sx(bi); end
        OP_CONJ:   begin re_x = sx(ar);          im_x = -sx(ai);         end
        default:   ;
      endcase
    end
  end

  assign red_re = reduce(re_x);
  assign red_im = reduce(im_x);

  logic       is_mul;
  logic [1:0] last_step;
  assign is_mul    = (opr_q == OP_CMUL) || (opr_q == OP_EMUL);
  assign last_step = (opr_q == OP_EMUL) ? 2'd1 : 2'd3;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    opr_d    = opr_q;
    step_d   = step_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = inA;
          b_d     = inB;
          opr_d   = opr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mul) begin
          acc_re_d = '0;
          acc_im_d = '0;
          step_d   = '0;
          state_d  = S_MUL;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          case (opr_q)
            OP_PASS_A, OP_PASS_B, OP_ADD, OP_SUB, OP_CONJ: begin
              out_d = {red_re[W-1:0], red_im[W-1:0]};
              ovf_d = red_re[W] | red_im[W];
            end
            OP_EQ:   out_d = {{(2*W-1){1'b0}}, (a_q == b_q)};
            default: begin
              out_d = '0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        step_d = step_q + 2'd1;
        if (opr_q == OP_CMUL) begin
          case (step_q)
            2'd0:    acc_re_d = acc_re_q + prod_x;
            2'd1:    acc_re_d = acc_re_q - prod_x;
            default: acc_im_d = acc_im_q + prod_x;
          endcase
        end else if (step_q == 2'd0) begin
          acc_re_d = acc_re_q + prod_x;
        end else begin
          acc_im_d = acc_im_q + prod_x;
        end
        if (step_q == last_step) state_d = S_WB;
      end
      S_WB: begin
        out_d   = {red_re[W-1:0], red_im[W-1:0]};
        ovf_d   = red_re[W] | red_im[W];
        err_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      opr_q    <= '0;
      step_q   <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opr_q    <= opr_d;
      step_q   <= step_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_q    <= out_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign outAB = out_q;
  assign ovf   = ovf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_complex_alu_seq.sv
// Scoreboard bench for complex_alu_seq: stimulus pushes expected results, a negedge monitor checks each done.
module tb_complex_alu_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opr   = 4'b0;
  logic [31:0] inA   = '0;
  logic [31:0] inB   = '0;
  logic        busy, done, ovf, err;
  logic [31:0] outAB;

  complex_alu_seq #(.W(16), .FRAC(8)) dut (
    .clock(clock), .reset(reset), .start(start), .opr(opr),
    .inA(inA), .inB(inB), .busy(busy), .done(done),
    .outAB(outAB), .ovf(ovf), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic        err;
    int          due;
    int          lat;
  } exp_t;

  exp_t  sb[$];
  string names[$];
  int    checks = 0;
  int    failures = 0;
  int    busy_run = 0;
  exp_t  mon_e;
  string mon_n;

  localparam logic [31:0] A0 = 32'h01000200;
  localparam logic [31:0] B0 = 32'h0300FF00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          mon_e = sb.pop_front();
          mon_n = names.pop_front();
          chk({mon_n, "_out"}, outAB, mon_e.out);
          chk({mon_n, "_ovf"}, ovf, mon_e.ovf);
          chk({mon_n, "_err"}, err, mon_e.err);
          chk({mon_n, "_latency"}, cyc, mon_e.due);
          chk({mon_n, "_busy_cycles"}, busy_run, mon_e.lat);
          chk({mon_n, "_busy_in_done"}, busy, 1'b0);
        end
        busy_run = 0;
      end
    end
  end

  // Called at a negedge; the next posedge is the accepting edge.
  task automatic issue(input string name, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo, input logic eovf,
                       input logic eerr, input int lat);
    exp_t e;
    start = 1'b1;
    opr   = o;
    inA   = a;
    inB   = b;
    @(posedge clock);
    #1;
    e.out = eo;
    e.ovf = eovf;
    e.err = eerr;
    e.due = cyc + lat;
    e.lat = lat;
    sb.push_back(e);
    names.push_back(name);
    @(negedge clock);
    start = 1'b0;
    opr   = 4'b0000;
    inA   = ~a;
    inB   = ~b;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: pending results %0d expected 0", sb.size());
      sb.delete();
      names.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outAB", outAB, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_err", err, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    issue("cmul", 4'b0100, A0, B0, 32'h05000500, 1'b0, 1'b0, 6);
    drain();

    issue("add", 4'b0010, A0, B0, 32'h04000100, 1'b0, 1'b0, 1);
    @(negedge clock);
    chk("b2b_done_cycle", done, 1'b1);
    issue("sub_b2b", 4'b0011, A0, B0, 32'hFE000300, 1'b0, 1'b0, 1);
    drain();

    issue("pass_a", 4'b0000, A0, B0, A0, 1'b0, 1'b0, 1);
    drain();
    issue("pass_b", 4'b0001, A0, B0, B0, 1'b0, 1'b0, 1);
    drain();
    issue("emul", 4'b0110, A0, B0, 32'h0300FE00, 1'b0, 1'b0, 4);
    drain();
    issue("conj", 4'b1011, A0, B0, 32'h0100FE00, 1'b0, 1'b0, 1);
    drain();
`ifdef CALU_SAT_EN
    issue("conj_min", 4'b1011, 32'h00008000, B0, 32'h00007FFF, 1'b1, 1'b0, 1);
`else
    issue("conj_min", 4'b1011, 32'h00008000, B0, 32'h00008000, 1'b1, 1'b0, 1);
`endif
    drain();
    issue("eq_same", 4'b1000, 32'h12345678, 32'h12345678, 32'h00000001, 1'b0, 1'b0, 1);
    drain();
    issue("eq_diff", 4'b1000, 32'h12345678, 32'h12345679, 32'h00000000, 1'b0, 1'b0, 1);
    drain();
    issue("invalid", 4'b1111, A0, B0, 32'h00000000, 1'b0, 1'b1, 1);
    drain();

    issue("cmul_ignore", 4'b0100, A0, B0, 32'h05000500, 1'b0, 1'b0, 6);
    @(negedge clock);
    start = 1'b1;
    opr   = 4'b0001;
    inA   = 32'hDEADBEEF;
    inB   = 32'h0BADF00D;
    @(negedge clock);
    start = 1'b0;
    drain();
    repeat (8) @(negedge clock);

`ifdef CALU_SAT_EN
    issue("add_ovf", 4'b0010, 32'h7FFF0000, 32'h00010000, 32'h7FFF0000, 1'b1, 1'b0, 1);
`else
    issue("add_ovf", 4'b0010, 32'h7FFF0000, 32'h00010000, 32'h80000000, 1'b1, 1'b0, 1);
`endif
    drain();

    issue("cmul_reset", 4'b0100, A0, B0, 32'h05000500, 1'b0, 1'b0, 6);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    names.delete();
    @(negedge clock);
    chk("midreset_outAB", outAB, 32'h0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_done", done, 1'b0);
    chk("midreset_ovf", ovf, 1'b0);
    chk("midreset_err", err, 1'b0);
    reset = 1'b0;
    busy_run = 0;
    repeat (10) @(negedge clock);

    issue("after_reset", 4'b0001, A0, B0, B0, 1'b0, 1'b0, 1);
    drain();
    issue("after_reset_cmul", 4'b0100, A0, B0, 32'h05000500, 1'b0, 1'b0, 6);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
